alu_arbiter: RTL and testbench

Shares one combinational ALU core between two requesters (port 0: pipeline EX stage, port 1: auxiliary sequencer such as a multi-cycle address/compare helper) with valid/ready handshakes. Grants one request per cycle, round-robin or fixed priority, and returns a registered result tagged with the winning port ID. Sits between the EX-stage operand muxes and the EX/MEM pipeline register.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_core.sv | 38 +++
 rtl/alu_arbiter.sv | 106 ++++++++++
 tb/tb_alu_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes, default widths and the port tag type.
package alu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int SEL_WIDTH  = 4;

    localparam logic [SEL_WIDTH-1:0] ALU_ADD = 4'd0;
    localparam logic [SEL_WIDTH-1:0] ALU_SUB = 4'd1;
    localparam logic [SEL_WIDTH-1:0] ALU_SLL = 4'd2;
    localparam logic [SEL_WIDTH-1:0] ALU_XOR = 4'd3;
    localparam logic [SEL_WIDTH-1:0] ALU_OR  = 4'd4;
    localparam logic [SEL_WIDTH-1:0] ALU_AND = 4'd5;
    localparam logic [SEL_WIDTH-1:0] ALU_SRL = 4'd6;
    localparam logic [SEL_WIDTH-1:0] ALU_EQ  = 4'd7;
    localparam logic [SEL_WIDTH-1:0] ALU_NE  = 4'd8;
    localparam logic [SEL_WIDTH-1:0] ALU_LT  = 4'd9;
    localparam logic [SEL_WIDTH-1:0] ALU_GE  = 4'd10;

    // Requester identity, also used as the grant pointer
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: select/operands -> result and branch condition.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int SEL_WIDTH  = alu_pkg::SEL_WIDTH
) (
    input  logic [SEL_WIDTH-1:0]  i_select,
    input  logic [DATA_WIDTH-1:0] i_in_1,
    input  logic [DATA_WIDTH-1:0] i_in_2,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_bcond
);

    // Operation decode; shift amounts of DATA_WIDTH or more shift everything out
    always_comb begin
        o_result = '0;
        o_bcond  = 1'b0;
        case (i_select)
            ALU_ADD: o_result = i_in_1 + i_in_2;
            ALU_SUB: o_result = i_in_1 - i_in_2;
            ALU_SLL: o_result = i_in_1 << i_in_2;
            ALU_XOR: o_result = i_in_1 ^ i_in_2;
            ALU_OR:  o_result = i_in_1 | i_in_2;
            ALU_AND: o_result = i_in_1 & i_in_2;
            ALU_SRL: o_result = i_in_1 >> i_in_2;
            ALU_EQ:  o_bcond  = (i_in_1 == i_in_2);
            ALU_NE:  o_bcond  = (i_in_1 != i_in_2);
            ALU_LT:  o_bcond  = (i_in_1 <  i_in_2);
            ALU_GE:  o_bcond  = (i_in_1 >= i_in_2);
            default: begin
                o_result = '0;
                o_bcond  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one ALU core; registered, port-tagged response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int SEL_WIDTH  = alu_pkg::SEL_WIDTH,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [SEL_WIDTH-1:0]  req0_select,
    input  logic [DATA_WIDTH-1:0] req0_in_1,
    input  logic [DATA_WIDTH-1:0] req0_in_2,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [SEL_WIDTH-1:0]  req1_select,
    input  logic [DATA_WIDTH-1:0] req1_in_1,
    input  logic [DATA_WIDTH-1:0] req1_in_2,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_bcond
);

    port_e                 r_last_grant;
    logic                  r_rsp_valid;
    port_e                 r_rsp_id;
    logic [DATA_WIDTH-1:0] r_rsp_result;
    logic                  r_rsp_bcond;

    port_e                 w_grant;
    logic                  w_space;
    logic                  w_accept;
    logic [SEL_WIDTH-1:0]  w_select;
    logic [DATA_WIDTH-1:0] w_in_1;
    logic [DATA_WIDTH-1:0] w_in_2;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_bcond;

    assign w_space = !r_rsp_valid || rsp_ready;

    // Grant selection: lone requester wins; ties go to port 0 or alternate
    always_comb begin
        w_grant = PORT0;
        if (req1_valid && !req0_valid) begin
            w_grant = PORT1;
        end else if (req0_valid && req1_valid && (FIXED_PRIO == 0) && (r_last_grant == PORT0)) begin
            w_grant = PORT1;
        end
    end

    assign req0_ready = w_space && req0_valid && (w_grant == PORT0);
    assign req1_ready = w_space && req1_valid && (w_grant == PORT1);
    assign w_accept   = req0_ready || req1_ready;

    // Steer the granted request's operands into the shared core
    always_comb begin
        w_select = req0_select;
        w_in_1   = req0_in_1;
        w_in_2   = req0_in_2;
        if (w_grant == PORT1) begin
            w_select = req1_select;
            w_in_1   = req1_in_1;
            w_in_2   = req1_in_2;
        end
    end

    alu_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_alu_core (
        .i_select (w_select),
        .i_in_1   (w_in_1),
        .i_in_2   (w_in_2),
        .o_result (w_result),
        .o_bcond  (w_bcond)
    );

    // Response register and grant pointer; a new accept replaces a consumed response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= PORT0;
            r_rsp_result <= '0;
            r_rsp_bcond  <= 1'b0;
            r_last_grant <= PORT1;
        end else if (w_accept) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_grant;
            r_rsp_result <= w_result;
            r_rsp_bcond  <= w_bcond;
            r_last_grant <= w_grant;
        end else if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_bcond  = r_rsp_bcond;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: one round-robin and one fixed-priority instance.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: round-robin instance, index 1: fixed-priority instance
    logic        rst [2];
    logic        v0 [2];
    logic        v1 [2];
    logic [3:0]  s0 [2];
    logic [3:0]  s1 [2];
    logic [31:0] a0 [2];
    logic [31:0] b0 [2];
    logic [31:0] a1 [2];
    logic [31:0] b1 [2];
    logic        rr [2];
    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        o_rv [2];
    logic        o_id [2];
    logic [31:0] o_res [2];
    logic        o_bc [2];

    alu_arbiter #(.DATA_WIDTH(32), .SEL_WIDTH(4), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset(rst[0]),
        .req0_valid(v0[0]), .req0_ready(rdy0[0]), .req0_select(s0[0]), .req0_in_1(a0[0]), .req0_in_2(b0[0]),
        .req1_valid(v1[0]), .req1_ready(rdy1[0]), .req1_select(s1[0]), .req1_in_1(a1[0]), .req1_in_2(b1[0]),
        .rsp_valid(o_rv[0]), .rsp_ready(rr[0]), .rsp_id(o_id[0]), .rsp_result(o_res[0]), .rsp_bcond(o_bc[0])
    );

    alu_arbiter #(.DATA_WIDTH(32), .SEL_WIDTH(4), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(rst[1]),
        .req0_valid(v0[1]), .req0_ready(rdy0[1]), .req0_select(s0[1]), .req0_in_1(a0[1]), .req0_in_2(b0[1]),
        .req1_valid(v1[1]), .req1_ready(rdy1[1]), .req1_select(s1[1]), .req1_in_1(a1[1]), .req1_in_2(b1[1]),
        .rsp_valid(o_rv[1]), .rsp_ready(rr[1]), .rsp_id(o_id[1]), .rsp_result(o_res[1]), .rsp_bcond(o_bc[1])
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // reference model state per instance
    bit          mv [2];
    bit          mid [2];
    logic [31:0] mres [2];
    bit          mbc [2];
    bit          mlast [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void alu_ref(input int sel, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic bc);
        logic [4:0] sh;
        sh = b[4:0];
        r  = 32'd0;
        bc = 1'b0;
        case (sel)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = (b >= 32) ? 32'd0 : (a << sh);
            3:  r = a ^ b;
            4:  r = a | b;
            5:  r = a & b;
            6:  r = (b >= 32) ? 32'd0 : (a >> sh);
            7:  bc = (a == b);
            8:  bc = (a != b);
            9:  bc = (a < b);
            10: bc = (a >= b);
            default: ;
        endcase
    endfunction

    // One clock cycle on instance m: check readies mid-cycle, advance model, check response
    task automatic cycle(input int m, output bit acc0, output bit acc1);
        bit          sp, g, er0, er1;
        logic [31:0] r;
        logic        bc;
        @(negedge clk);
        sp = !mv[m] || rr[m];
        if (v0[m] && v1[m]) g = (m == 1) ? 1'b0 : !mlast[m];
        else                g = v1[m];
        er0 = sp && v0[m] && !g;
        er1 = sp && v1[m] && g;
        check_eq("req0_ready", {31'd0, rdy0[m]}, {31'd0, er0});
        check_eq("req1_ready", {31'd0, rdy1[m]}, {31'd0, er1});
        acc0 = er0 && !rst[m];
        acc1 = er1 && !rst[m];
        @(posedge clk);
        if (rst[m]) begin
            mv[m] = 0; mid[m] = 0; mres[m] = 0; mbc[m] = 0; mlast[m] = 1;
        end else if (er0 || er1) begin
            if (g) alu_ref(int'(s1[m]), a1[m], b1[m], r, bc);
            else   alu_ref(int'(s0[m]), a0[m], b0[m], r, bc);
            mv[m] = 1; mid[m] = g; mres[m] = r; mbc[m] = bc; mlast[m] = g;
        end else if (rr[m]) begin
            mv[m] = 0;
        end
        #1;
        check_eq("rsp_valid",  {31'd0, o_rv[m]}, {31'd0, mv[m]});
        check_eq("rsp_id",     {31'd0, o_id[m]}, {31'd0, mid[m]});
        check_eq("rsp_result", o_res[m], mres[m]);
        check_eq("rsp_bcond",  {31'd0, o_bc[m]}, {31'd0, mbc[m]});
    endtask

    task automatic do_reset(input int m);
        bit x, y;
        v0[m] = 0; v1[m] = 0; rst[m] = 1;
        cycle(m, x, y);
        rst[m] = 0;
    endtask

    // Directed single op on port 0 with constant expectations
    task automatic single(input int m, input string tag, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic eb);
        bit x, y;
        v0[m] = 1; v1[m] = 0; s0[m] = sel; a0[m] = a; b0[m] = b; rr[m] = 1;
        cycle(m, x, y);
        v0[m] = 0;
        check_eq({tag, "_acc"},   {31'd0, x}, 32'd1);
        check_eq({tag, "_valid"}, {31'd0, o_rv[m]}, 32'd1);
        check_eq({tag, "_id"},    {31'd0, o_id[m]}, 32'd0);
        check_eq({tag, "_res"},   o_res[m], er);
        check_eq({tag, "_bc"},    {31'd0, o_bc[m]}, {31'd0, eb});
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 40));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    // Random traffic; a pending (valid, unaccepted) request is held except for rare legal drops
    task automatic rand_run(input int m, input int n);
        bit acc0 = 1, acc1 = 1;
        for (int i = 0; i < n; i++) begin
            if (!(v0[m] && !acc0) || $urandom_range(0, 15) == 0) begin
                v0[m] = ($urandom_range(0, 3) != 0);
                s0[m] = 4'($urandom_range(0, 15));
                a0[m] = rand_opnd();
                b0[m] = ($urandom_range(0, 3) == 0) ? a0[m] : rand_opnd();
            end
            if (!(v1[m] && !acc1) || $urandom_range(0, 15) == 0) begin
                v1[m] = ($urandom_range(0, 3) != 0);
                s1[m] = 4'($urandom_range(0, 15));
                a1[m] = rand_opnd();
                b1[m] = ($urandom_range(0, 3) == 0) ? a1[m] : rand_opnd();
            end
            rr[m]  = ($urandom_range(0, 3) != 0);
            rst[m] = ($urandom_range(0, 99) == 0);
            cycle(m, acc0, acc1);
        end
        rst[m] = 0;
    endtask

    initial begin
        bit x, y;
        logic [31:0] held;
        for (int m = 0; m < 2; m++) begin
            rst[m] = 1; v0[m] = 0; v1[m] = 0; s0[m] = 0; s1[m] = 0;
            a0[m] = 0; b0[m] = 0; a1[m] = 0; b1[m] = 0; rr[m] = 0;
            mv[m] = 0; mid[m] = 0; mres[m] = 0; mbc[m] = 0; mlast[m] = 1;
        end

        // ---------------- round-robin instance ----------------
        do_reset(0);
        check_eq("reset_valid", {31'd0, o_rv[0]}, 32'd0);
        check_eq("reset_res",   o_res[0], 32'd0);
        single(0, "add", 4'd0, 32'd5, 32'd7, 32'd12, 1'b0);

        // both valid every cycle, grants alternate 0,1,0,1 after reset
        do_reset(0);
        v0[0] = 1; s0[0] = 4'd0; a0[0] = 32'd1; b0[0] = 32'd2;
        v1[0] = 1; s1[0] = 4'd1; a1[0] = 32'd3; b1[0] = 32'd5;
        rr[0] = 1;
        for (int k = 0; k < 4; k++) begin
            cycle(0, x, y);
            check_eq("rr_id", {31'd0, o_id[0]}, 32'(k % 2));
            if (k % 2 == 1) check_eq("rr_sub", o_res[0], 32'hFFFF_FFFE);
            else            check_eq("rr_add", o_res[0], 32'd3);
        end

        // backpressure: drain, accept one, then hold rsp_ready low 3 cycles
        v0[0] = 0; v1[0] = 0;
        cycle(0, x, y);
        v0[0] = 1; s0[0] = 4'd3; a0[0] = 32'hF0F0_1234; b0[0] = 32'h0F0F_0000;
        v1[0] = 1; rr[0] = 0;
        cycle(0, x, y);
        held = o_res[0];
        s0[0] = 4'd4; a0[0] = 32'h1; b0[0] = 32'h2;
        for (int k = 0; k < 3; k++) begin
            cycle(0, x, y);
            check_eq("bp_ready0", {31'd0, x}, 32'd0);
            check_eq("bp_ready1", {31'd0, y}, 32'd0);
            check_eq("bp_stable", o_res[0], held);
        end
        rr[0] = 1;
        cycle(0, x, y);
        check_eq("bp_release", {31'd0, x | y}, 32'd1);
        v0[0] = 0; v1[0] = 0;

        single(0, "eq",    4'd7,  32'd9,          32'd9,  32'd0, 1'b1);
        single(0, "lt",    4'd9,  32'hFFFF_FFFF,  32'd1,  32'd0, 1'b0);
        single(0, "sll32", 4'd2,  32'd1,          32'd32, 32'd0, 1'b0);
        single(0, "srl",   4'd6,  32'h8000_0000,  32'd31, 32'd1, 1'b0);
        single(0, "sel13", 4'd13, 32'h1234_5678,  32'h9,  32'd0, 1'b0);

        // reset while a response is pending and not taken
        v0[0] = 1; s0[0] = 4'd0; a0[0] = 32'd4; b0[0] = 32'd4; rr[0] = 0;
        cycle(0, x, y);
        v0[0] = 0; rst[0] = 1;
        cycle(0, x, y);
        rst[0] = 0;
        check_eq("rst_mid_valid", {31'd0, o_rv[0]}, 32'd0);
        v0[0] = 1; v1[0] = 1; rr[0] = 1;
        cycle(0, x, y);
        check_eq("rst_tie_id", {31'd0, o_id[0]}, 32'd0);
        v0[0] = 0; v1[0] = 0;

        rand_run(0, 600);

        // ---------------- fixed-priority instance ----------------
        do_reset(1);
        v0[1] = 1; s0[1] = 4'd5; a0[1] = 32'hFF00; b0[1] = 32'h0FF0;
        v1[1] = 1; s1[1] = 4'd10; a1[1] = 32'd7; b1[1] = 32'd7;
        rr[1] = 1;
        for (int k = 0; k < 4; k++) begin
            cycle(1, x, y);
            check_eq("fp_id0", {31'd0, o_id[1]}, 32'd0);
            check_eq("fp_res", o_res[1], 32'h0F00);
        end
        v0[1] = 0;
        cycle(1, x, y);
        check_eq("fp_port1_acc", {31'd0, y}, 32'd1);
        check_eq("fp_port1_id",  {31'd0, o_id[1]}, 32'd1);
        check_eq("fp_port1_bc",  {31'd0, o_bc[1]}, 32'd1);
        v1[1] = 0;

        rand_run(1, 600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
